// File: rtl/result_unpacker_pkg.sv
// Shared packing constants for the operand buffer and the result unpacker.
// Defines element widths and the half-select encoding once.
package result_unpacker_pkg;
  localparam int ELEM_W = 32;
  localparam int PAIR_W = 64;
  localparam logic HALF_HI = 1'b0;
  localparam logic HALF_LO = 1'b1;
endpackage

// File: rtl/result_unpacker_mem.sv
// Result entry storage: DEPTH x PAIR_W registers.
// Synchronous write port, asynchronous read port; contents are not reset.
module result_unpacker_mem
  import result_unpacker_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [PAIR_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [PAIR_W-1:0] rdata
);
  logic [PAIR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/result_unpacker.sv
// Queues 64-bit result beats and replays them as 32-bit words, high half first.
// Define RESULT_UNPACKER_OVF_EN to add the ovf / drop_cnt overflow monitor.
module result_unpacker
  import result_unpacker_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PAIR_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW+1:0]     word_count
`ifdef RESULT_UNPACKER_OVF_EN
  ,
  output logic              ovf,
  output logic [15:0]       drop_cnt
`endif
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic [AW:0]       cnt_n;
  logic              half;
  logic              half_n;
  logic              full;
  logic              push;
  logic              pop;
  logic              retire;
  logic [PAIR_W-1:0] head;

  assign full = (cnt == FULL);
  assign in_ready = !full && !rst;
  assign out_valid = (cnt != '0);
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign retire = pop && (half == HALF_LO);
  assign out_data = (half == HALF_LO) ? head[ELEM_W-1:0]
                                      : head[PAIR_W-1:ELEM_W];

  result_unpacker_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push && !clear),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_comb begin
    cnt_n = cnt;
    half_n = half;
    if (clear) begin
      cnt_n = '0;
      half_n = HALF_HI;
    end else begin
      if (push) cnt_n = cnt_n + ONE;
      if (retire) cnt_n = cnt_n - ONE;
      if (pop) half_n = ~half;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      half <= HALF_HI;
      word_count <= '0;
    end else begin
      cnt <= cnt_n;
      half <= half_n;
      // count of pending words: two per entry, minus one if the high half left
      word_count <= {cnt_n, 1'b0} - (AW+2)'(half_n);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (retire) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

`ifdef RESULT_UNPACKER_OVF_EN
  logic drop;
  assign drop = in_valid && full && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_result_unpacker.sv
// Randomized and directed bench for result_unpacker against a word-queue model.
// Build with RESULT_UNPACKER_OVF_EN defined to also cover ovf / drop_cnt.
module tb_result_unpacker;
  import result_unpacker_pkg::*;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  word_count;
`ifdef RESULT_UNPACKER_OVF_EN
  logic        ovf;
  logic [15:0] drop_cnt;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  bit          acc;
  bit          ovf_m;
  int          drop_m;

  always #5 clk = ~clk;

  result_unpacker #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_count(word_count)
`ifdef RESULT_UNPACKER_OVF_EN
    ,
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // entries still holding at least one pending word
  function automatic int entries();
    return (q.size() + 1) / 2;
  endfunction

  function automatic void model_reset();
    q.delete();
    ovf_m = 1'b0;
    drop_m = 0;
  endfunction

  task automatic compare();
    check("in_ready", in_ready, entries() < DEPTH);
    check("out_valid", out_valid, q.size() > 0);
    check("word_count", word_count, q.size());
    if (q.size() > 0) check("out_data", out_data, q[0]);
`ifdef RESULT_UNPACKER_OVF_EN
    check("ovf", ovf, ovf_m);
    check("drop_cnt", drop_cnt, drop_m);
`endif
  endtask

  // compare, drive one cycle of inputs, then apply their effect to the model
  task automatic cyc(input logic cl, input logic iv, input logic [63:0] d,
                     input logic ordy);
    bit rdy;
    bit full;
    @(negedge clk);
    compare();
    clear = cl;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    rdy = entries() < DEPTH;
    full = !rdy;
    acc = 1'b0;
    if (cl) begin
      q.delete();
      ovf_m = 1'b0;
      drop_m = 0;
    end else begin
      if (iv && full) begin
        ovf_m = 1'b1;
        if (drop_m < 16'hFFFF) drop_m++;
      end
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && rdy) begin
        q.push_back(d[63:32]);
        q.push_back(d[31:0]);
        acc = 1'b1;
      end
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] beat;
    int          got;
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    model_reset();
    #13;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_word_count", word_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic order
    cyc(0, 1, 64'hAAAA0001_BBBB0002, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);

    // stall across a pair
    cyc(0, 1, 64'h1111_2222_3333_4444, 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);

    // fill, hold beat 17 for three cycles while full, then drain
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, rnd64(), 0);
    beat = rnd64();
    for (int i = 0; i < 3; i++) cyc(0, 1, beat, 0);
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    check("full_words", word_count, 2 * DEPTH);
`ifdef RESULT_UNPACKER_OVF_EN
    check("ovf_set", ovf, 1'b1);
    check("drop_3", drop_cnt, 3);
`endif
    got = 0;
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      cyc(0, got == 0, beat, 1);
      if (acc) got = 1;
    end
    check("drain_empty", q.size(), 0);
    check("beat17_taken", got, 1);

    // concurrent stream of 40 beats, pointers wrap
    got = 0;
    beat = rnd64();
    for (int i = 0; i < 200 && got < 40; i++) begin
      cyc(0, 1, beat, 1);
      if (acc) begin
        got++;
        beat = rnd64();
      end
    end
    check("stream_40", got, 40);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);

    // clear with concurrent beat after 5 entries queued
    for (int i = 0; i < 5; i++) cyc(0, 1, rnd64(), 0);
    cyc(1, 1, rnd64(), 0);
    cyc(0, 0, '0, 1);

    // overflow then clear
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, rnd64(), 0);
    cyc(1, 0, '0, 0);
    cyc(0, 0, '0, 0);

    // randomized mix
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(60) == 0), ($urandom_range(3) != 0), rnd64(),
          ($urandom_range(2) != 0));
    end

    // reset mid-cycle with data queued
    for (int i = 0; i < 4; i++) cyc(0, 1, rnd64(), 0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    clear = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_words", word_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1, 64'hCAFE0001_F00D0002, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
